// File: rtl/accum_alarm_unit.sv
// Accumulate-and-compare alarm engine: a Moore FSM steps a saturating accumulator over
// NSTEPS bank sums, then registers a threshold alarm.
module accum_alarm_unit #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned W      = 2,
  parameter int unsigned NSTEPS = 3,
  parameter int unsigned ACCW   = 4,
  parameter int unsigned STICKY = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic                abort,
  input  logic [NSTEPS-1:0]   src_mask,
  input  logic [NCH*W-1:0]    a_in,
  input  logic [NCH*W-1:0]    b_in,
  input  logic [ACCW-1:0]     thr,
  input  logic                cmp_ge,
  input  logic                alarm_clr,
  output logic                busy,
  output logic                done,
  output logic [ACCW-1:0]     acc_out,
  output logic                sat,
  output logic                alarm
);

  localparam int unsigned SumW  = W + $clog2(NCH + 1);
  localparam int unsigned TotW  = ((ACCW > SumW) ? ACCW : SumW) + 1;
  localparam int unsigned StepW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [StepW-1:0] LastStep = StepW'(NSTEPS - 1);
  localparam logic [TotW-1:0]  AccMax   = TotW'({ACCW{1'b1}});

  typedef enum logic [1:0] {StIdle, StAcc, StEval, StDone} state_e;

  state_e              state_q, state_d;
  logic [StepW-1:0]    step_q, step_d;
  logic [ACCW-1:0]     acc_q, acc_d;
  logic                sat_q, sat_d;
  logic                alarm_q, alarm_d;
  logic [NSTEPS-1:0]   mask_q, mask_d;
  logic [ACCW-1:0]     thr_q, thr_d;
  logic                cmp_ge_q, cmp_ge_d;

  logic [NSTEPS-1:0]   mask_sh;
  logic [NCH*W-1:0]    bank;
  logic [SumW-1:0]     sum;
  logic [TotW-1:0]     total;
  logic                cond;

  // Datapath: bank sum is kept wide enough that the saturation test sees the true total.
  always_comb begin
    mask_sh = mask_q >> step_q;
    bank    = mask_sh[0] ? a_in : b_in;
    sum     = '0;
    for (int i = 0; i < NCH; i++) begin
      sum = sum + SumW'(bank[i*W +: W]);
    end
    total = TotW'(acc_q) + TotW'(sum);
    cond  = cmp_ge_q ? (acc_q >= thr_q) : (acc_q > thr_q);
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    alarm_d  = alarm_q;
    mask_d   = mask_q;
    thr_d    = thr_q;
    cmp_ge_d = cmp_ge_q;
    if (alarm_clr) begin
      alarm_d = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        acc_d  = '0;
        step_d = '0;
        if (go && !abort) begin
          state_d  = StAcc;
          mask_d   = src_mask;
          thr_d    = thr;
          cmp_ge_d = cmp_ge;
          sat_d    = 1'b0;
        end
      end
      StAcc: begin
        if (total > AccMax) begin
          acc_d = '1;
          sat_d = 1'b1;
        end else begin
          acc_d = total[ACCW-1:0];
        end
        step_d = step_q + 1'b1;
        if (step_q == LastStep) begin
          state_d = StEval;
          step_d  = '0;
        end
      end
      StEval: begin
        // The evaluation result takes precedence over a coincident alarm_clr.
        alarm_d = (STICKY != 0) ? (alarm_q | cond) : cond;
        state_d = StDone;
      end
      StDone: begin
        if (!go) begin
          state_d = StIdle;
          acc_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort drops the run without evaluating; alarm and sat keep their prior values.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      acc_d   = '0;
      step_d  = '0;
      sat_d   = sat_q;
      alarm_d = alarm_clr ? 1'b0 : alarm_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      step_q   <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
      alarm_q  <= 1'b0;
      mask_q   <= '0;
      thr_q    <= '0;
      cmp_ge_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      alarm_q  <= alarm_d;
      mask_q   <= mask_d;
      thr_q    <= thr_d;
      cmp_ge_q <= cmp_ge_d;
    end
  end

  assign busy    = (state_q == StAcc) || (state_q == StEval);
  assign done    = (state_q == StDone);
  assign acc_out = acc_q;
  assign sat     = sat_q;
  assign alarm   = alarm_q;

endmodule

// File: doc/accum_alarm_unit.md
Name: accum_alarm_unit

Overview:
- Parametrised accumulate-and-compare alarm engine: Moore control FSM plus datapath.
- Per step, selects one of two NCH-channel operand banks and adds all channels into a saturating accumulator.
- After NSTEPS steps, compares the accumulator against a programmable threshold and registers the alarm.
- Adds runtime threshold and compare mode, per-step source mask, abort, saturation flag and optional sticky alarm.

Parameters:
- NCH, 2: number of operand channels per bank.
- W, 2: width of each operand channel (unsigned).
- NSTEPS, 3: accumulation steps per run; must be >= 1.
- ACCW, 4: accumulator and threshold width; must be >= W.
- STICKY, 0: 1 = alarm latches until alarm_clr; 0 = alarm is overwritten each run.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- go  in  1  start request; level-held, sampled in IDLE and DONE.
- abort  in  1  cancel current run.
- src_mask  in  NSTEPS  bit k=1: step k uses bank A; 0: bank B.
- a_in  in  NCH*W  bank A; channel i = a_in[i*W +: W].
- b_in  in  NCH*W  bank B; same packing as a_in.
- thr  in  ACCW  compare threshold.
- cmp_ge  in  1  1: alarm condition is acc>=thr; 0: acc>thr.
- alarm_clr  in  1  clears alarm.
- busy  out  1  high in ACC or EVAL.
- done  out  1  high in DONE.
- acc_out  out  ACCW  accumulator register.
- sat  out  1  accumulator saturated during the current or last run.
- alarm  out  1  registered alarm.

Behaviour:
- Reset (async): state=IDLE, step=0, acc=0, sat=0, alarm=0, busy=0, done=0. Latched config is cleared to 0.
- States: IDLE, ACC, EVAL, DONE. All outputs are Moore outputs (decoded from registers only).
- IDLE:
  - acc<=0 every cycle; step<=0.
  - go=1 and abort=0 -> ACC. On this edge, latch src_mask, thr, cmp_ge and clear sat.
- ACC:
  - Each cycle, S = sum of the NCH channels of the selected bank (bank given by latched src_mask[step]), computed without loss.
  - acc <= min(acc+S, 2^ACCW-1). If the true sum exceeds 2^ACCW-1, sat<=1.
  - step increments each cycle; at step==NSTEPS-1 -> EVAL.
  - a_in and b_in are sampled live every ACC cycle.
- EVAL (1 cycle): compute cond from acc and the latched thr/cmp_ge.
  - STICKY=0: alarm<=cond.
  - STICKY=1: alarm<=alarm|cond.
  - Next state is DONE.
- DONE:
  - done=1; acc and alarm hold.
  - go=1 -> stay in DONE; go=0 -> IDLE.
  - A fresh run needs go low for at least one cycle.
- Latency: go seen in IDLE in cycle 0; ACC in cycles 1..NSTEPS; EVAL in cycle NSTEPS+1; done=1 and alarm valid from cycle NSTEPS+2 (cycle 5 with defaults).
- abort=1 in any non-IDLE state -> IDLE on the next edge. alarm and sat hold; acc is cleared by IDLE; done is never asserted for that run. abort has priority over go.
- alarm_clr=1: alarm<=0 on the next edge, in any state. Exception: when coincident with EVAL, the EVAL update wins.
- thr and cmp_ge changes mid-run have no effect (latched at start). src_mask changes mid-run have no effect.
- Operand values are unsigned. acc never wraps.

Test Plan (defaults NCH=2, W=2, NSTEPS=3, ACCW=4, STICKY=0 unless noted):
1. Basic/no alarm: src_mask=001, a_in={1,1}, b_in={1,0}, thr=5, cmp_ge=0, go held high.
   - Expect busy in cycles 1-4.
   - acc 2 -> 3 -> 4.
   - done=1 at cycle 5 with acc_out=4, alarm=0, sat=0.
   - Drop go -> IDLE next edge, acc_out=0.
2. Compare boundary: a_in={2,1}, b_in={1,0}, src_mask=001, thr=5 -> acc=5.
   - cmp_ge=0 -> alarm=0.
   - Rerun with cmp_ge=1 -> alarm=1.
   - Changing thr to 0 mid-run -> result unchanged.
3. Saturation: src_mask=111, a_in={3,3}.
   - Expect acc 6 -> 12 -> 15 (true sum 18).
   - sat=1, alarm=1 with thr=5.
   - Next normal run -> sat cleared on start.
4. Abort: start the scenario-1 run with a previous alarm=1; assert abort in cycle 2 (ACC).
   - Next edge -> IDLE, busy=0, acc_out=0.
   - done never asserted; alarm stays 1.
   - abort together with go in IDLE -> stays IDLE.
5. Sticky (STICKY=1):
   - Run with acc=8 -> alarm=1.
   - Run with acc=4 -> alarm stays 1.
   - Pulse alarm_clr in IDLE -> alarm=0 next edge.
   - alarm_clr coincident with EVAL where cond=1 -> alarm=1.
6. Async reset asserted mid-EVAL and mid-DONE -> busy, done, alarm, sat and acc_out go to 0 immediately, without a clock edge. After release, a go run completes normally in 5 cycles.
